// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: PC-tagged FIFO with valid/ready head,
// fetch-enable back-pressure, and flush with a post-flush drop window for stale fetches.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          INFLIGHT = 1,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                request_data,
  input  logic                       fetch_data_valid,
  output logic                       fetch_en,
  input  logic                       flush,
  input  logic [31:0]                flush_pc,
  output logic [31:0]                id_inst,
  output logic [31:0]                id_pc,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = (INFLIGHT < 1) ? 1 : $clog2(INFLIGHT + 1);
  localparam logic [CW-1:0] FETCH_LIMIT = CW'(DEPTH - INFLIGHT);
  localparam logic [CW-1:0] FULL_COUNT  = CW'(DEPTH);

  logic [31:0]   r_inst_mem [DEPTH];
  logic [31:0]   r_pc_mem   [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_tag_pc;
  logic [DW-1:0] r_drop_cnt;
  logic          r_overflow;

  logic w_full;
  logic w_dropping;
  logic w_offer;
  logic w_pop;
  logic w_push;
  logic w_overflow;

  assign w_full     = (r_count == FULL_COUNT);
  assign w_dropping = (r_drop_cnt != '0);
  assign w_offer    = fetch_data_valid & ~flush & ~w_dropping;
  assign w_pop      = id_valid & id_ready & ~flush;
  // A pop frees the head slot in the same cycle, so a full queue may still accept.
  assign w_push     = w_offer & (~w_full | w_pop);
  assign w_overflow = w_offer & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_tag_pc   <= RESET_PC;
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
      // NOTE: storage is cleared on reset so the combinational head outputs read zero
      // straight out of reset instead of whatever the array powered up with.
      for (int i = 0; i < DEPTH; i++) begin
        r_inst_mem[i] <= '0;
        r_pc_mem[i]   <= '0;
      end
    end else if (flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_tag_pc   <= flush_pc;
      r_drop_cnt <= DW'(INFLIGHT);
    end else begin
      if (w_dropping) r_drop_cnt <= r_drop_cnt - DW'(1);
      if (w_push) begin
        r_inst_mem[r_wr_ptr] <= request_data;
        r_pc_mem[r_wr_ptr]   <= r_tag_pc;
        r_wr_ptr             <= r_wr_ptr + AW'(1);
        r_tag_pc             <= r_tag_pc + 32'd4;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_overflow) r_overflow <= 1'b1;
    end
  end

  assign id_valid     = (r_count != '0);
  assign id_inst      = r_inst_mem[r_rd_ptr];
  assign id_pc        = r_pc_mem[r_rd_ptr];
  assign count        = r_count;
  assign overflow_err = r_overflow;
  // Stop fetching while fewer than INFLIGHT+1 slots remain, leaving room for late responses.
  assign fetch_en     = ~rst & ~flush & (r_count < FETCH_LIMIT);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a scoreboard of {pc, inst} is filled as words are
// offered and drained whenever decode pops the head.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] request_data;
  logic        fetch_data_valid;
  logic        fetch_en;
  logic        flush;
  logic [31:0] flush_pc;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_valid;
  logic        id_ready;
  logic [2:0]  count;
  logic        overflow_err;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t      sb[$];
  logic [31:0] exp_pc;
  int          n_checks = 0;
  int          n_fail   = 0;

  fetch_queue #(.DEPTH(4), .INFLIGHT(1), .RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .rst              (rst),
    .request_data     (request_data),
    .fetch_data_valid (fetch_data_valid),
    .fetch_en         (fetch_en),
    .flush            (flush),
    .flush_pc         (flush_pc),
    .id_inst          (id_inst),
    .id_pc            (id_pc),
    .id_valid         (id_valid),
    .id_ready         (id_ready),
    .count            (count),
    .overflow_err     (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle from the falling edge; acc says the bench expects the word to be stored.
  task automatic step(input logic v, input logic [31:0] d, input logic rdy,
                      input logic fl, input logic [31:0] fpc, input logic acc);
    entry_t e;
    fetch_data_valid = v;
    request_data     = d;
    id_ready         = rdy;
    flush            = fl;
    flush_pc         = fpc;
    #1;
    if (id_valid && rdy && !fl && !rst) begin
      if (sb.size() == 0) begin
        check("pop_unexpected", {31'd0, id_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("pop_inst", id_inst, e.inst);
        check("pop_pc", id_pc, e.pc);
      end
    end
    if (fl) begin
      sb.delete();
      exp_pc = fpc;
    end
    if (acc) begin
      sb.push_back({exp_pc, d});
      exp_pc = exp_pc + 32'd4;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; request_data = '0; fetch_data_valid = 1'b0;
    flush = 1'b0; flush_pc = '0; id_ready = 1'b0;
    exp_pc = 32'h0000_0000;
    repeat (2) @(posedge clk);
    @(negedge clk);

    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(id_valid), 32'd0);
    check("rst_inst", id_inst, 32'd0);
    check("rst_pc", id_pc, 32'd0);
    check("rst_ovf", 32'(overflow_err), 32'd0);
    check("rst_fetch_en", 32'(fetch_en), 32'd0);
    rst = 1'b0;
    #1;
    check("fetch_en_after_rst", 32'(fetch_en), 32'd1);

    // 1: three words streamed straight through
    step(1'b1, 32'h0000_0013, 1'b1, 1'b0, '0, 1'b1);
    check("t1_valid_after_push", 32'(id_valid), 32'd1);
    check("t1_count1", 32'(count), 32'd1);
    step(1'b1, 32'h0010_0093, 1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 32'h0020_0113, 1'b1, 1'b0, '0, 1'b1);
    check("t1_count_steady", 32'(count), 32'd1);
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    check("t1_count_drained", 32'(count), 32'd0);
    check("t1_valid_drained", 32'(id_valid), 32'd0);

    // 2: decode stalled, fetch_en falls at count 3, in-flight word fills the last slot
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 32'h0000_1000 + 32'(i), 1'b0, 1'b0, '0, 1'b1);
      check("t2_count", 32'(count), 32'(i));
      check("t2_fetch_en", 32'(fetch_en), (i < 3) ? 32'd1 : 32'd0);
      check("t2_head_pc_held", id_pc, 32'h0000_000C);
      check("t2_head_inst_held", id_inst, 32'h0000_1001);
    end
    check("t2_ovf", 32'(overflow_err), 32'd0);

    // 3: full queue, simultaneous push and pop
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 32'h0000_2000 + 32'(i), 1'b1, 1'b0, '0, 1'b1);
      check("t3_count_full", 32'(count), 32'd4);
    end
    check("t3_ovf", 32'(overflow_err), 32'd0);

    // 4: flush with two entries held and a word arriving in the flush cycle
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    check("t4_count_before", 32'(count), 32'd2);
    flush = 1'b1;
    #1;
    check("t4_fetch_en_flush", 32'(fetch_en), 32'd0);
    step(1'b1, 32'hBAD0_0001, 1'b1, 1'b1, 32'h0000_0100, 1'b0);
    check("t4_count_flushed", 32'(count), 32'd0);
    check("t4_valid_flushed", 32'(id_valid), 32'd0);
    step(1'b1, 32'hBAD0_0002, 1'b0, 1'b0, '0, 1'b0);
    check("t4_drop_count", 32'(count), 32'd0);
    step(1'b1, 32'h0000_3000, 1'b0, 1'b0, '0, 1'b1);
    check("t4_count_after", 32'(count), 32'd1);
    check("t4_pc_after_flush", id_pc, 32'h0000_0100);
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);

    // 5: overflow when full with decode stalled, sticky until reset
    for (int i = 0; i < 4; i++) step(1'b1, 32'h0000_4000 + 32'(i), 1'b0, 1'b0, '0, 1'b1);
    check("t5_count_full", 32'(count), 32'd4);
    step(1'b1, 32'hBAD0_0003, 1'b0, 1'b0, '0, 1'b0);
    check("t5_ovf_set", 32'(overflow_err), 32'd1);
    check("t5_count_kept", 32'(count), 32'd4);
    check("t5_head_kept", id_pc, 32'h0000_0104);
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    check("t5_ovf_sticky", 32'(overflow_err), 32'd1);
    rst = 1'b1;
    step(1'b1, 32'hBAD0_0004, 1'b1, 1'b1, 32'h0000_0500, 1'b0);
    check("t5_rst_count", 32'(count), 32'd0);
    check("t5_rst_valid", 32'(id_valid), 32'd0);
    check("t5_rst_inst", id_inst, 32'd0);
    check("t5_rst_pc", id_pc, 32'd0);
    check("t5_rst_ovf", 32'(overflow_err), 32'd0);
    check("t5_rst_fetch_en", 32'(fetch_en), 32'd0);
    sb.delete();
    exp_pc = 32'h0000_0000;
    rst = 1'b0;

    // 6: tag PC wraps through 0xFFFF_FFFC to 0
    step(1'b0, '0, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0);
    step(1'b1, 32'hBAD0_0005, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 32'h0000_6000, 1'b1, 1'b0, '0, 1'b1);
    check("t6_first_pc", id_pc, 32'hFFFF_FFF8);
    step(1'b1, 32'h0000_6001, 1'b1, 1'b0, '0, 1'b1);
    check("t6_second_pc", id_pc, 32'hFFFF_FFFC);
    step(1'b1, 32'h0000_6002, 1'b1, 1'b0, '0, 1'b1);
    check("t6_wrap_pc", id_pc, 32'h0000_0000);
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    check("t6_count_drained", 32'(count), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
